// File: rtl/ifq_pkg.sv
// Shared helpers and default-configuration types for the multi-issue fetch queue.
package ifq_pkg;

  localparam int IFQ_DATA_WIDTH     = 32;
  localparam int IFQ_INSTR_PER_LINE = 4;

  function automatic int line_bytes(input int instr_per_line);
    return instr_per_line * 4;
  endfunction

  // Word index of a byte address within its cache line.
  function automatic int unsigned word_off(input logic [31:0] addr, input int instr_per_line);
    return (addr >> 2) % instr_per_line;
  endfunction

  typedef logic [IFQ_DATA_WIDTH*IFQ_INSTR_PER_LINE-1:0] ifq_line_t;

  typedef struct packed {
    logic [IFQ_DATA_WIDTH-1:0] instr;
    logic [IFQ_DATA_WIDTH-1:0] pc;
  } ifq_slot_t;

endpackage

// File: rtl/ifq_line_buf.sv
// Line storage for the fetch queue: one write port, combinational reads of head and head+1.
module ifq_line_buf
  import ifq_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [LINE_W-1:0] o_head,
  output logic [LINE_W-1:0] o_next
);

  logic [LINE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  w_next_addr;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Depth is a power of two, so the increment wraps naturally.
  assign w_next_addr = i_raddr + PTR_W'(1);
  assign o_head      = r_mem[i_raddr];
  assign o_next      = r_mem[w_next_addr];

endmodule

// File: rtl/ifq_multi_issue.sv
// Multi-issue instruction fetch queue. Optional same-cycle bypass of an empty queue
// is enabled by defining IFQ_BYPASS_EN.
module ifq_multi_issue
  import ifq_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int INSTR_PER_LINE = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int ISSUE_WIDTH    = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
  localparam int LINE_W = DATA_WIDTH * INSTR_PER_LINE,
  localparam int CNT_W  = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [DATA_WIDTH-1:0]             fetch_pc,
  input  logic [LINE_W-1:0]                 line_data,
  input  logic                              line_valid,
  output logic                              line_ready,
  input  logic                              redirect_valid,
  input  logic [DATA_WIDTH-1:0]             redirect_pc,
  output logic [ISSUE_WIDTH-1:0]            out_valid,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] out_instr,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] out_pc,
  input  logic [CNT_W-1:0]                  deq_num,
  output logic                              empty
);

  localparam int OFF_W      = $clog2(INSTR_PER_LINE);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_RW     = $clog2(FIFO_DEPTH) + 1;
  localparam int AV_W       = $clog2(FIFO_DEPTH * INSTR_PER_LINE) + 1;
  localparam int LINE_BYTES = line_bytes(INSTR_PER_LINE);

  logic [PTR_W-1:0]      r_wp, r_rp;
  logic [CNT_RW-1:0]     r_count;
  logic [OFF_W-1:0]      r_off;
  logic [DATA_WIDTH-1:0] r_pc_base, r_fetch_pc;

  logic              w_accept, w_bypass, w_pop;
  logic [AV_W-1:0]   w_avail;
  logic [LINE_W-1:0] w_head, w_next;
  logic [CNT_W-1:0]  w_nvalid, w_deq;
  logic [OFF_W:0]    w_off_sum;
  logic [ISSUE_WIDTH-1:0] w_valid;

  assign line_ready = (r_count != CNT_RW'(FIFO_DEPTH));
  assign w_accept   = line_valid && line_ready && !redirect_valid;
  assign empty      = (r_count == '0);
  assign fetch_pc   = r_fetch_pc;
  assign out_valid  = w_valid;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_accept && (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Guarded so a redirect leaves a stale offset with no stored line without underflow.
  assign w_avail = (r_count == '0) ? '0
                 : AV_W'(r_count) * AV_W'(INSTR_PER_LINE) - AV_W'(r_off);

  ifq_line_buf #(
    .LINE_W (LINE_W),
    .DEPTH  (FIFO_DEPTH),
    .PTR_W  (PTR_W)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_wp),
    .i_wdata (line_data),
    .i_raddr (r_rp),
    .o_head  (w_head),
    .o_next  (w_next)
  );

  generate
    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
      logic [OFF_W:0]    w_idx;
      logic [OFF_W-1:0]  w_word;
      logic              w_cross;
      logic [LINE_W-1:0] w_src;

      assign w_idx   = {1'b0, r_off} + (OFF_W + 1)'(gi);
      assign w_word  = w_idx[OFF_W-1:0];
      assign w_cross = w_idx[OFF_W];
      assign w_src   = w_bypass ? line_data : (w_cross ? w_next : w_head);

      assign out_instr[gi*DATA_WIDTH +: DATA_WIDTH] = w_src[w_word*DATA_WIDTH +: DATA_WIDTH];
      assign out_pc[gi*DATA_WIDTH +: DATA_WIDTH]    = r_pc_base + DATA_WIDTH'(4 * gi);
      assign w_valid[gi] = w_bypass ? !w_cross : (AV_W'(gi) < w_avail);
    end
  endgenerate

  always_comb begin
    w_nvalid = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      w_nvalid = w_nvalid + CNT_W'(w_valid[i]);
    end
  end

  // Over-consumption is clamped so an illegal deq_num cannot corrupt pointers.
  assign w_deq     = redirect_valid ? '0 : ((deq_num > w_nvalid) ? w_nvalid : deq_num);
  assign w_off_sum = {1'b0, r_off} + (OFF_W + 1)'(w_deq);
  assign w_pop     = w_off_sum[OFF_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_off      <= '0;
      r_pc_base  <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_off      <= OFF_W'(word_off(32'(redirect_pc), INSTR_PER_LINE));
      r_pc_base  <= redirect_pc;
      r_fetch_pc <= redirect_pc & ~DATA_WIDTH'(LINE_BYTES - 1);
    end else begin
      if (w_accept) begin
        r_wp       <= r_wp + PTR_W'(1);
        r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(LINE_BYTES);
      end
      if (w_pop) r_rp <= r_rp + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_RW'(1);
        2'b01:   r_count <= r_count - CNT_RW'(1);
        default: r_count <= r_count;
      endcase
      r_off     <= w_off_sum[OFF_W-1:0];
      r_pc_base <= r_pc_base + (DATA_WIDTH'(w_deq) << 2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) assert (deq_num <= w_nvalid);
  end

endmodule

// File: tb/tb_ifq_multi_issue.sv
// Scoreboard bench for ifq_multi_issue: instruction-level queue model, directed plus random stimulus.
module tb_ifq_multi_issue;
  import ifq_pkg::*;

  localparam int DW    = 32;
  localparam int IPL   = 4;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int CNT_W = $clog2(IW + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DW-1:0]        fetch_pc;
  ifq_line_t            line_data;
  logic                 line_valid;
  logic                 line_ready;
  logic                 redirect_valid;
  logic [DW-1:0]        redirect_pc;
  logic [IW-1:0]        out_valid;
  logic [IW*DW-1:0]     out_instr;
  logic [IW*DW-1:0]     out_pc;
  logic [CNT_W-1:0]     deq_num;
  logic                 empty;

  ifq_multi_issue #(
    .DATA_WIDTH     (DW),
    .INSTR_PER_LINE (IPL),
    .FIFO_DEPTH     (DEPTH),
    .ISSUE_WIDTH    (IW),
    .RESET_PC       (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .line_data      (line_data),
    .line_valid     (line_valid),
    .line_ready     (line_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .deq_num        (deq_num),
    .empty          (empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0][DW-1:0] instr;
    logic [IW-1:0][DW-1:0] pc;
    logic [DW-1:0]         fetch;
    logic                  ready;
    logic                  empty;
    logic [7:0]            n;
  } exp_t;

  exp_t       exp_q[$];
  ifq_slot_t  mq[$];      // instructions still to be issued, program order
  int         lq[$];      // remaining words of each held line
  logic [31:0] m_fetch;
  int         m_off;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [IW-1:0] th;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      th = '0;
      for (int k = 0; k < IW; k++) if (k < int'(e.n)) th[k] = 1'b1;
      chk("out_valid", 64'(out_valid), 64'(th));
      for (int k = 0; k < IW; k++) begin
        if (k < int'(e.n)) begin
          chk($sformatf("slot%0d_instr", k), 64'(out_instr[k*DW +: DW]), 64'(e.instr[k]));
          chk($sformatf("slot%0d_pc", k), 64'(out_pc[k*DW +: DW]), 64'(e.pc[k]));
        end
      end
      chk("fetch_pc", 64'(fetch_pc), 64'(e.fetch));
      chk("line_ready", 64'(line_ready), 64'(e.ready));
      chk("empty", 64'(empty), 64'(e.empty));
    end
  end

  function automatic ifq_line_t mkline(input logic [31:0] b);
    ifq_line_t l;
    for (int i = 0; i < IPL; i++) l[i*DW +: DW] = 32'(b * (i + 1));
    return l;
  endfunction

  function automatic ifq_line_t rndline();
    ifq_line_t l;
    for (int i = 0; i < IPL; i++) l[i*DW +: DW] = $urandom;
    return l;
  endfunction

  task automatic push_line(input ifq_line_t ld);
    ifq_slot_t s;
    $display("accept line @%h from word %0d", m_fetch, m_off);
    lq.push_back(IPL - m_off);
    for (int i = m_off; i < IPL; i++) begin
      s.instr = ld[i*DW +: DW];
      s.pc    = m_fetch + 32'(4 * i);
      mq.push_back(s);
    end
    m_fetch = m_fetch + 32'(IPL * 4);
    m_off   = 0;
  endtask

  task automatic pop_word();
    void'(mq.pop_front());
    lq[0] = lq[0] - 1;
    if (lq[0] == 0) void'(lq.pop_front());
  endtask

  // Drives one cycle, records its expected outputs, then advances the model.
  task automatic step(input bit lv, input ifq_line_t ld, input bit rv,
                      input logic [31:0] rpc, input int dq_req);
    exp_t e;
    int   nvis, dq;
    bit   acc, byp;
    acc = lv && (lq.size() != DEPTH) && !rv;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = acc && (lq.size() == 0);
`endif
    e       = '0;
    e.fetch = m_fetch;
    e.ready = (lq.size() != DEPTH);
    e.empty = (lq.size() == 0);
    if (byp) push_line(ld);
    nvis = (mq.size() < IW) ? mq.size() : IW;
    e.n  = 8'(nvis);
    for (int k = 0; k < nvis; k++) begin
      e.instr[k] = mq[k].instr;
      e.pc[k]    = mq[k].pc;
    end
    dq = (dq_req < nvis) ? dq_req : nvis;
    line_valid     = lv;
    line_data      = ld;
    redirect_valid = rv;
    redirect_pc    = rpc;
    deq_num        = CNT_W'(dq);
    exp_q.push_back(e);
    if (rv) begin
      $display("redirect to %h", rpc);
      mq.delete();
      lq.delete();
      m_off   = int'((rpc >> 2) % IPL);
      m_fetch = rpc & ~32'(IPL * 4 - 1);
    end else begin
      if (acc && !byp) push_line(ld);
      repeat (dq) pop_word();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; line_valid = 1'b0; line_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; deq_num = '0;
    m_fetch = 32'h0; m_off = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    step(1'b1, mkline(32'h11), 1'b0, 32'h0, 0);
    step(1'b0, '0, 1'b0, 32'h0, 0);
    step(1'b1, mkline(32'h55), 1'b0, 32'h0, 0);
    step(1'b0, '0, 1'b0, 32'h0, 2);
    step(1'b0, '0, 1'b0, 32'h0, 2);
    step(1'b0, '0, 1'b0, 32'h0, 1);

    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, mkline(32'h100 + 32'(i)), 1'b0, 32'h0, 0);
    step(1'b1, mkline(32'h200), 1'b0, 32'h0, 2);
    step(1'b0, '0, 1'b0, 32'h0, 2);
    step(1'b0, '0, 1'b0, 32'h0, 0);

    step(1'b1, mkline(32'h9), 1'b1, 32'h108, 2);
    step(1'b0, '0, 1'b0, 32'h0, 0);
    step(1'b1, mkline(32'hA0), 1'b0, 32'h0, 0);
    step(1'b0, '0, 1'b0, 32'h0, 0);
    step(1'b0, '0, 1'b0, 32'h0, 2);

    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(0, 3) != 0), rndline(), ($urandom_range(0, 31) == 0),
           {22'h0, 8'($urandom_range(0, 255)), 2'b00},
           (c % 300 < 60) ? 0 : int'($urandom_range(0, IW)));
    end
    line_valid = 1'b0;
    deq_num    = '0;

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifq_multi_issue.md
# ifq_multi_issue

Parametrised instruction fetch queue, successor to the single-issue IFQ. Sits between the instruction cache and decode/dispatch. Buffers whole cache lines and presents up to ISSUE_WIDTH consecutive instructions per cycle, each with its PC. Handles redirects to any word offset within a line, and optionally bypasses an empty queue.

## Interface
- DATA_WIDTH, 32, instruction and PC width
- INSTR_PER_LINE, 4, instructions per cache line; power of 2, at least 2
- FIFO_DEPTH, 4, line entries; power of 2
- ISSUE_WIDTH, 2, output slots; 1 to INSTR_PER_LINE
- RESET_PC, 0, first fetch address; line-aligned
- Derived: LINE_W = DATA_WIDTH*INSTR_PER_LINE; CNT_W = $clog2(ISSUE_WIDTH+1)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- fetch_pc  out  DATA_WIDTH  line-aligned address requested from cache
- line_data  in  LINE_W  cache line for fetch_pc; word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- line_valid  in  1  line_data valid this cycle
- line_ready  out  1  queue accepts a line (= ~full)
- redirect_valid  in  1  jump/branch redirect
- redirect_pc  in  DATA_WIDTH  redirect target; word-aligned
- out_valid  out  ISSUE_WIDTH  thermometer-coded; slot k valid implies slots below k valid
- out_instr  out  ISSUE_WIDTH*DATA_WIDTH  slot k instruction
- out_pc  out  ISSUE_WIDTH*DATA_WIDTH  slot k PC
- deq_num  in  CNT_W  instructions consumed this cycle, lowest slots first
- empty  out  1  no stored instructions

## Operation
- **State:** the line buffer; wp and rp line pointers; a line count; rd_off, the word offset in the head line; pc_base, the PC of slot 0; and fetch_pc.
- **Accept:** a line is accepted when line_valid && line_ready && !redirect_valid. The line is written at wp, wp and count are incremented, and fetch_pc += INSTR_PER_LINE*4.
- **Available words:** avail = count*INSTR_PER_LINE - rd_off.
- **Slot k:**
  - Presents word (rd_off+k) mod INSTR_PER_LINE.
  - Reads the head line, or the next line when rd_off+k >= INSTR_PER_LINE.
  - Is valid when k < avail.
  - out_pc[k] = pc_base + 4*k, modulo 2^DATA_WIDTH.
- **Dequeue:**
  - rd_off += deq_num and pc_base += 4*deq_num.
  - When the offset crosses the line end, it wraps and the head line is popped (rp++, count--).
  - At most one line is popped per cycle.
- **deq_num > popcount(out_valid)** is illegal. Covered by an assertion; the state must not corrupt.
- **Redirect (highest priority):**
  - Flushes the queue: count=0, wp=rp=0.
  - rd_off = redirect_pc word offset; pc_base = redirect_pc; fetch_pc = redirect_pc with its line offset cleared.
  - deq_num and any line presented in the same cycle are ignored.
  - The first line that arrives after a redirect is consumed starting at rd_off.
- **Full:** line_ready = (count != FIFO_DEPTH), computed from registered count. A pop in the same cycle does not free the slot.
- **Simultaneous accept and pop:** count is unchanged and both pointers advance.

## Timing
- Reset values:
  - fetch_pc = pc_base = RESET_PC
  - count = rd_off = 0, wp = rp = 0
  - out_valid = 0, empty = 1, line_ready = 1
  - out_instr and out_pc are don't-care while invalid
- Line accept to out_valid: 1 cycle without bypass.
- fetch_pc updates one cycle after accept or redirect.
- Redirect in cycle N:
  - Earliest line for the new target is accepted in cycle N+1.
  - Without bypass, instructions are valid in cycle N+2.
- Pointers wrap modulo FIFO_DEPTH; the count register is $clog2(FIFO_DEPTH)+1 bits.

## Configuration
- **IFQ_BYPASS_EN defined:**
  - When empty && accept, the slots present words from line_data directly, starting at rd_off, in the same cycle.
  - deq_num applies in that cycle. The line is still written, then the dequeue is applied to it.
  - Zero-cycle latency to issue.
- **IFQ_BYPASS_EN undefined:**
  - Outputs come only from stored lines.
  - Slots whose word would come from the incoming line are invalid.

## Structure
- **Package ifq_pkg:**
  - LINE_BYTES function of INSTR_PER_LINE
  - Word-offset extraction function
  - Typedef for the packed line type
  - Typedef for the {instr, pc} slot struct
- **Sub-module ifq_line_buf:**
  - FIFO_DEPTH x LINE_W register array with one write port
  - Two combinational line reads (head and head+1) for slots that cross a line boundary
  - Pointer and count logic stays in the top module.

## Test plan
- **Reset, then single line:** rst, then line_valid with words 0x11..0x44 at fetch_pc 0x0.
  - fetch_pc becomes 0x10.
  - Next cycle, out_instr = {0x22, 0x11}, out_pc = {0x4, 0x0}, out_valid = 2'b11.
- **Dual dequeue across a line boundary:** two lines queued; deq_num=2 for two cycles, then deq_num=1.
  - Slot 0 = word 0 of line 1, slot 1 = word 1.
  - rp advances exactly once.
- **Full backpressure:** FIFO_DEPTH lines accepted with deq_num=0.
  - line_ready = 0; a further line_valid does not move fetch_pc.
  - After deq_num=2 drains 4 words, line_ready returns to 1 the next cycle.
- **Mid-line redirect:** redirect_valid with redirect_pc = 0x108, together with line_valid and deq_num=2.
  - Queue empty; fetch_pc = 0x100.
  - Once the next line is accepted, out_pc = {0x10C, 0x108} and slot 0 = word 2.
- **Bypass (IFQ_BYPASS_EN):** empty queue, line accepted with deq_num=1.
  - Same cycle: out_valid = 2'b11 and out_instr[0] = word 0.
  - Next cycle: slot 0 = word 1, pc_base = 0x4.
- **Odd offset, single issue (ISSUE_WIDTH=1):** redirect to 0x0C, then two lines.
  - Issue sequence: PCs 0x0C, 0x10, 0x14, ... with no bubbles when deq_num=1 every cycle.
